// File: rtl/ram_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ram_fifo_pkg
// Shared constants for the RAM-backed FIFO controller and the 18-bit
// dual-port RAM primitive it drives.
//   DATAWID   : RAM word width.
//   WEWID     : number of byte write-enables per port.
//   BYTEWID   : bits covered by one byte write-enable.
//   WENB_ALL  : active-low byte enables with every byte written.
//   WENB_NONE : active-low byte enables with no byte written.
// ---------------------------------------------------------------------------
package ram_fifo_pkg;

  localparam int DATAWID = 18;
  localparam int WEWID   = 2;
  localparam int BYTEWID = DATAWID / WEWID;

  localparam logic [WEWID-1:0] WENB_ALL  = 2'b00;
  localparam logic [WEWID-1:0] WENB_NONE = 2'b11;

endpackage : ram_fifo_pkg

// File: rtl/ram_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl_if
// User-side FIFO bundle between a producer/consumer and ram_fifo_ctrl.
//   master : the FIFO user (drives FLUSH/PUSH/DIN/POP, observes status).
//   slave  : the controller (observes requests, drives status).
// Signals:
//   FLUSH, PUSH, POP, DIN            : requests and write data.
//   POP_VALID                        : RAM QB holds popped data this cycle.
//   COUNT                            : occupancy, ADDRWID+1 bits.
//   FULL/EMPTY/ALMOST_FULL/ALMOST_EMPTY : status flags.
//   OVERFLOW/UNDERFLOW               : sticky error flags.
// ---------------------------------------------------------------------------
interface ram_fifo_ctrl_if
  import ram_fifo_pkg::*;
#(
  parameter int ADDRWID = 8
);

  logic               FLUSH;
  logic               PUSH;
  logic [DATAWID-1:0] DIN;
  logic               POP;
  logic               POP_VALID;
  logic [ADDRWID:0]   COUNT;
  logic               FULL;
  logic               EMPTY;
  logic               ALMOST_FULL;
  logic               ALMOST_EMPTY;
  logic               OVERFLOW;
  logic               UNDERFLOW;

  modport master (
    output FLUSH, PUSH, DIN, POP,
    input  POP_VALID, COUNT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
           OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  FLUSH, PUSH, DIN, POP,
    output POP_VALID, COUNT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
           OVERFLOW, UNDERFLOW
  );

endinterface : ram_fifo_ctrl_if

// File: rtl/ram.sv
// ---------------------------------------------------------------------------
// ram
// Behavioural model of the 18-bit dual-port RAM primitive driven by
// ram_fifo_ctrl. All strobes are active-low; each port is synchronous to
// its own clock. A port is selected by CENx=0; WENx=0 writes (bytes gated
// by WENBx), WENx=1 reads into Qx on the clock edge.
// This model implements port B as read-only: the FIFO controller never
// writes through it, so its write-side pins are accepted but ignored.
// Ports:
//   CLKA/CLKB   : port clocks.
//   AA/AB       : port addresses.
//   CENA/CENB   : chip enables.
//   WENA/WENB   : write enables.
//   WENBA/WENBB : byte write enables.
//   DA/DB       : write data.
//   QA/QB       : registered read data.
// ---------------------------------------------------------------------------
module ram
  import ram_fifo_pkg::*;
#(
  parameter int ADDRWID = 8
) (
  input  logic               CLKA,
  input  logic               CLKB,
  input  logic [ADDRWID-1:0] AA,
  input  logic [ADDRWID-1:0] AB,
  input  logic               CENA,
  input  logic               CENB,
  input  logic               WENA,
  input  logic               WENB,
  input  logic [WEWID-1:0]   WENBA,
  input  logic [WEWID-1:0]   WENBB,
  input  logic [DATAWID-1:0] DA,
  input  logic [DATAWID-1:0] DB,
  output logic [DATAWID-1:0] QA,
  output logic [DATAWID-1:0] QB
);

  logic [DATAWID-1:0] r_mem [1 << ADDRWID];

  // NOTE: storage arrays take no reset; clearing every word would need a
  // reset fan-out to the whole array and stop it mapping onto RAM macros.
  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values, independent of the order the statements run in.
  always_ff @(posedge CLKA) begin
    if (!CENA) begin
      if (!WENA) begin
        for (int b = 0; b < WEWID; b++) begin
          if (!WENBA[b]) begin
            r_mem[AA][b*BYTEWID +: BYTEWID] <= DA[b*BYTEWID +: BYTEWID];
          end
        end
      end else begin
        QA <= r_mem[AA];
      end
    end
  end

  always_ff @(posedge CLKB) begin
    if (!CENB && WENB) begin
      QB <= r_mem[AB];
    end
  end

  wire w_unused_portb_write = ^{WENBB, DB};

endmodule : ram

// File: rtl/ram_fifo_flags.sv
// ---------------------------------------------------------------------------
// ram_fifo_flags
// Maps the registered occupancy count onto the FIFO status flags. Purely
// combinational from i_count, so no request input can reach a flag.
// Ports:
//   i_count        : occupancy, 0..DEPTH.
//   o_full         : i_count == DEPTH.
//   o_empty        : i_count == 0.
//   o_almost_full  : i_count >= DEPTH - AF_MARGIN.
//   o_almost_empty : i_count <= AE_MARGIN.
// ---------------------------------------------------------------------------
module ram_fifo_flags #(
  parameter int ADDRWID   = 8,
  parameter int AF_MARGIN = 4,
  parameter int AE_MARGIN = 4
) (
  input  logic [ADDRWID:0] i_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty
);

  localparam int DEPTH = 1 << ADDRWID;

  localparam logic [ADDRWID:0] L_DEPTH  = (ADDRWID+1)'(DEPTH);
  localparam logic [ADDRWID:0] L_AF_THR = (ADDRWID+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDRWID:0] L_AE_THR = (ADDRWID+1)'(AE_MARGIN);

  assign o_full         = (i_count == L_DEPTH);
  assign o_empty        = (i_count == '0);
  assign o_almost_full  = (i_count >= L_AF_THR);
  assign o_almost_empty = (i_count <= L_AE_THR);

endmodule : ram_fifo_flags

// File: rtl/ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl
// Single-clock FIFO controller sequencing the 18-bit dual-port RAM: port A
// is the write port, port B the read port. Owns the pointers, occupancy
// count, status and sticky error flags; popped data is RAM QB, qualified
// one cycle later by POP_VALID.
// Ports:
//   CLK    : single clock (also clocks the RAM on both ports).
//   RST_N  : asynchronous active-low reset.
//   fifo   : slave side of ram_fifo_ctrl_if (requests, data, status).
//   AA/AB  : RAM write/read addresses (write and read pointers).
//   CENA/CENB/WENA/WENB : RAM strobes, active-low.
//   WENBA/WENBB         : RAM byte write-enables, active-low.
//   DA/DB               : RAM write data (DB tied off).
// ---------------------------------------------------------------------------
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int ADDRWID   = 8,
  parameter int AF_MARGIN = 4,
  parameter int AE_MARGIN = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  ram_fifo_ctrl_if.slave     fifo,
  output logic [ADDRWID-1:0] AA,
  output logic [ADDRWID-1:0] AB,
  output logic               CENA,
  output logic               CENB,
  output logic               WENA,
  output logic               WENB,
  output logic [WEWID-1:0]   WENBA,
  output logic [WEWID-1:0]   WENBB,
  output logic [DATAWID-1:0] DA,
  output logic [DATAWID-1:0] DB
);

  logic [ADDRWID-1:0] r_wr_ptr;
  logic [ADDRWID-1:0] r_rd_ptr;
  logic [ADDRWID:0]   r_count;
  logic               r_pop_valid;
  logic               r_overflow;
  logic               r_underflow;

  logic w_full;
  logic w_empty;
  logic w_almost_full;
  logic w_almost_empty;
  logic w_push_ok;
  logic w_pop_ok;

  ram_fifo_flags #(
    .ADDRWID   (ADDRWID),
    .AF_MARGIN (AF_MARGIN),
    .AE_MARGIN (AE_MARGIN)
  ) u_flags (
    .i_count        (r_count),
    .o_full         (w_full),
    .o_empty        (w_empty),
    .o_almost_full  (w_almost_full),
    .o_almost_empty (w_almost_empty)
  );

  // Acceptance looks only at registered flags, so a full FIFO still takes a
  // pop (freeing a slot next cycle) while rejecting the simultaneous push.
  assign w_push_ok = fifo.PUSH & ~w_full  & ~fifo.FLUSH;
  assign w_pop_ok  = fifo.POP  & ~w_empty & ~fifo.FLUSH;

  // Write port. CENA is additionally held high while reset is asserted so
  // the RAM sees no access while the pointers are being cleared.
  assign AA    = r_wr_ptr;
  assign DA    = fifo.DIN;
  assign CENA  = ~(w_push_ok & RST_N);
  assign WENA  = ~w_push_ok;
  assign WENBA = WENB_ALL;

  // Read port: never writes, so a dual-write collision cannot arise.
  assign AB    = r_rd_ptr;
  assign CENB  = ~(w_pop_ok & RST_N);
  assign WENB  = 1'b1;
  assign WENBB = WENB_NONE;
  assign DB    = '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (fifo.FLUSH) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Pointers are ADDRWID bits and wrap from DEPTH-1 to 0 on their own.
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDRWID'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ADDRWID'(1);

      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (ADDRWID+1)'(1);
        2'b01:   r_count <= r_count - (ADDRWID+1)'(1);
        default: r_count <= r_count;
      endcase

      // RAM QB is loaded on the same edge, so the two line up next cycle.
      r_pop_valid <= w_pop_ok;

      // Errors are sticky until FLUSH or reset.
      r_overflow  <= r_overflow  | (fifo.PUSH & w_full);
      r_underflow <= r_underflow | (fifo.POP  & w_empty);
    end
  end

  assign fifo.POP_VALID    = r_pop_valid;
  assign fifo.COUNT        = r_count;
  assign fifo.FULL         = w_full;
  assign fifo.EMPTY        = w_empty;
  assign fifo.ALMOST_FULL  = w_almost_full;
  assign fifo.ALMOST_EMPTY = w_almost_empty;
  assign fifo.OVERFLOW     = r_overflow;
  assign fifo.UNDERFLOW    = r_underflow;

endmodule : ram_fifo_ctrl

// File: tb/tb_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_fifo_ctrl
// Self-checking bench for ram_fifo_ctrl with the RAM model alongside it,
// using ADDRWID=4 (DEPTH=16), AF_MARGIN=4, AE_MARGIN=4. A reference model
// tracks occupancy and error flags; accepted push data goes into a
// scoreboard queue and is compared with RAM QB whenever POP_VALID is high.
// ---------------------------------------------------------------------------
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int AFM   = 4;
  localparam int AEM   = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  ram_fifo_ctrl_if #(.ADDRWID(AW)) fifo ();

  logic [AW-1:0]      AA, AB;
  logic               CENA, CENB, WENA, WENB;
  logic [WEWID-1:0]   WENBA, WENBB;
  logic [DATAWID-1:0] DA, DB, QB;
  logic [DATAWID-1:0] unused_qa;

  ram_fifo_ctrl #(
    .ADDRWID   (AW),
    .AF_MARGIN (AFM),
    .AE_MARGIN (AEM)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .fifo  (fifo),
    .AA    (AA),
    .AB    (AB),
    .CENA  (CENA),
    .CENB  (CENB),
    .WENA  (WENA),
    .WENB  (WENB),
    .WENBA (WENBA),
    .WENBB (WENBB),
    .DA    (DA),
    .DB    (DB)
  );

  ram #(.ADDRWID(AW)) u_ram (
    .CLKA  (CLK),
    .CLKB  (CLK),
    .AA    (AA),
    .AB    (AB),
    .CENA  (CENA),
    .CENB  (CENB),
    .WENA  (WENA),
    .WENB  (WENB),
    .WENBA (WENBA),
    .WENBB (WENBB),
    .DA    (DA),
    .DB    (DB),
    .QA    (unused_qa),
    .QB    (QB)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  int                 m_count;
  bit                 m_ovf, m_udf, m_pv;
  logic [DATAWID-1:0] sb[$];

  task automatic model_reset();
    m_count = 0;
    m_ovf   = 0;
    m_udf   = 0;
    m_pv    = 0;
    sb.delete();
  endtask

  // Scoreboard consumer: every POP_VALID cycle must deliver the oldest
  // accepted word on QB.
  always @(negedge CLK) begin
    if (RST_N && fifo.POP_VALID) begin
      logic [DATAWID-1:0] exp_q;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL pop_data: POP_VALID with no word expected, QB=%05h", QB);
      end else begin
        exp_q = sb.pop_front();
        if (QB !== exp_q) $display("FAIL pop_data: QB=%05h expected %05h", QB, exp_q);
        else n_pass++;
      end
    end
  end

  // One clock of stimulus: drive at the falling edge, check the RAM
  // strobes combinationally, then check registered state after the rise.
  task automatic drive_cycle(input bit push, input bit pop, input bit flush,
                             input logic [DATAWID-1:0] din);
    bit push_ok, pop_ok;
    @(negedge CLK);
    fifo.PUSH  = push;
    fifo.POP   = pop;
    fifo.FLUSH = flush;
    fifo.DIN   = din;
    push_ok = push && (m_count != DEPTH) && !flush;
    pop_ok  = pop  && (m_count != 0)     && !flush;
    #1;
    n_checks++;
    if (CENA !== !push_ok) $display("FAIL cena: CENA=%b expected %b", CENA, !push_ok);
    else n_pass++;
    n_checks++;
    if (CENB !== !pop_ok) $display("FAIL cenb: CENB=%b expected %b", CENB, !pop_ok);
    else n_pass++;
    @(posedge CLK);
    if (flush) begin
      model_reset();
    end else begin
      if (push && m_count == DEPTH) m_ovf = 1;
      if (pop  && m_count == 0)     m_udf = 1;
      if (push_ok) sb.push_back(din);
      m_count = m_count + int'(push_ok) - int'(pop_ok);
      m_pv    = pop_ok;
    end
    #1;
    n_checks++;
    if (fifo.COUNT !== (AW+1)'(m_count))
      $display("FAIL count: COUNT=%0d expected %0d", fifo.COUNT, m_count);
    else n_pass++;
    n_checks++;
    if (fifo.POP_VALID !== m_pv)
      $display("FAIL pop_valid: POP_VALID=%b expected %b", fifo.POP_VALID, m_pv);
    else n_pass++;
    n_checks++;
    if ({fifo.OVERFLOW, fifo.UNDERFLOW} !== {m_ovf, m_udf})
      $display("FAIL err_flags: OVF/UDF=%b%b expected %b%b",
               fifo.OVERFLOW, fifo.UNDERFLOW, m_ovf, m_udf);
    else n_pass++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, '0);
  endtask

  task automatic test_reset();
    fifo.PUSH  = 0;
    fifo.POP   = 0;
    fifo.FLUSH = 0;
    fifo.DIN   = '0;
    RST_N      = 0;
    model_reset();
    #12;
    n_checks++;
    if ({fifo.COUNT, fifo.POP_VALID, fifo.OVERFLOW, fifo.UNDERFLOW} !== {(AW+1)'(0), 3'b000})
      $display("FAIL reset_state: COUNT=%0d PV=%b OVF=%b UDF=%b expected 0 0 0 0",
               fifo.COUNT, fifo.POP_VALID, fifo.OVERFLOW, fifo.UNDERFLOW);
    else n_pass++;
    n_checks++;
    if ({fifo.EMPTY, fifo.ALMOST_EMPTY, fifo.FULL, fifo.ALMOST_FULL} !== 4'b1100)
      $display("FAIL reset_flags: E/AE/F/AF=%b%b%b%b expected 1100",
               fifo.EMPTY, fifo.ALMOST_EMPTY, fifo.FULL, fifo.ALMOST_FULL);
    else n_pass++;
    // A push request while in reset must not strobe the RAM.
    fifo.PUSH = 1;
    fifo.POP  = 1;
    #1;
    n_checks++;
    if ({CENA, CENB} !== 2'b11) $display("FAIL reset_cen: CENA/CENB=%b%b expected 11", CENA, CENB);
    else n_pass++;
    fifo.PUSH = 0;
    fifo.POP  = 0;
    @(negedge CLK);
    RST_N = 1;
  endtask

  task automatic test_basic();
    logic [DATAWID-1:0] words [3];
    words[0] = 18'h00001;
    words[1] = 18'h3FFFE;
    words[2] = 18'h2A5A5;
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, words[i]);
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, '0);
    idle(2);
    n_checks++;
    if ({fifo.COUNT, fifo.EMPTY} !== {(AW+1)'(0), 1'b1})
      $display("FAIL basic_drain: COUNT=%0d EMPTY=%b expected 0 1", fifo.COUNT, fifo.EMPTY);
    else n_pass++;
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1, 0, 0, 18'($urandom));
      n_checks++;
      if (fifo.ALMOST_FULL !== (m_count >= DEPTH - AFM))
        $display("FAIL almost_full: AF=%b at COUNT=%0d", fifo.ALMOST_FULL, m_count);
      else n_pass++;
      n_checks++;
      if (fifo.FULL !== (m_count == DEPTH))
        $display("FAIL full: FULL=%b at COUNT=%0d", fifo.FULL, m_count);
      else n_pass++;
    end
    // 17th push is rejected (CENA checked inside drive_cycle).
    drive_cycle(1, 0, 0, 18'h15555);
    n_checks++;
    if ({fifo.COUNT, fifo.OVERFLOW, fifo.FULL} !== {(AW+1)'(DEPTH), 2'b11})
      $display("FAIL overflow: COUNT=%0d OVF=%b FULL=%b expected 16 1 1",
               fifo.COUNT, fifo.OVERFLOW, fifo.FULL);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    drive_cycle(1, 1, 0, 18'h0BEEF);
    n_checks++;
    if ({fifo.COUNT, fifo.OVERFLOW} !== {(AW+1)'(DEPTH - 1), 1'b1})
      $display("FAIL simul_full: COUNT=%0d OVF=%b expected 15 1", fifo.COUNT, fifo.OVERFLOW);
    else n_pass++;
    for (int i = 0; i < DEPTH - 1; i++) drive_cycle(0, 1, 0, '0);
    idle(1);
    drive_cycle(1, 1, 0, 18'h2C0DE);
    n_checks++;
    if ({fifo.COUNT, fifo.UNDERFLOW, fifo.POP_VALID} !== {(AW+1)'(1), 2'b10})
      $display("FAIL simul_empty: COUNT=%0d UDF=%b PV=%b expected 1 1 0",
               fifo.COUNT, fifo.UNDERFLOW, fifo.POP_VALID);
    else n_pass++;
    drive_cycle(0, 1, 0, '0);
    idle(2);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) drive_cycle(1, 0, 0, 18'($urandom));
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1, 1, 0, 18'($urandom));
      n_checks++;
      if ({fifo.COUNT, fifo.ALMOST_EMPTY} !== {(AW+1)'(4), 1'b1})
        $display("FAIL stream: COUNT=%0d AE=%b expected 4 1", fifo.COUNT, fifo.ALMOST_EMPTY);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) drive_cycle(0, 1, 0, '0);
    idle(2);
  endtask

  task automatic test_flush();
    drive_cycle(0, 0, 1, '0);
    for (int i = 0; i < DEPTH + 1; i++) drive_cycle(1, 0, 0, 18'($urandom));
    for (int i = 0; i < 7; i++) drive_cycle(0, 1, 0, '0);
    idle(1);
    n_checks++;
    if ({fifo.COUNT, fifo.OVERFLOW} !== {(AW+1)'(9), 1'b1})
      $display("FAIL flush_setup: COUNT=%0d OVF=%b expected 9 1", fifo.COUNT, fifo.OVERFLOW);
    else n_pass++;
    // PUSH with FLUSH: CENA must stay high (checked in drive_cycle).
    drive_cycle(1, 0, 1, 18'h3A3A3);
    n_checks++;
    if ({fifo.COUNT, fifo.EMPTY, fifo.OVERFLOW} !== {(AW+1)'(0), 2'b10})
      $display("FAIL flush: COUNT=%0d EMPTY=%b OVF=%b expected 0 1 0",
               fifo.COUNT, fifo.EMPTY, fifo.OVERFLOW);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 0, 0, 18'h11111);
    drive_cycle(0, 1, 0, '0);
    fifo.POP = 0;
    #2;
    RST_N = 0;
    model_reset();
    #1;
    n_checks++;
    if ({fifo.POP_VALID, fifo.COUNT, fifo.EMPTY} !== {1'b0, (AW+1)'(0), 1'b1})
      $display("FAIL async_reset: PV=%b COUNT=%0d EMPTY=%b expected 0 0 1",
               fifo.POP_VALID, fifo.COUNT, fifo.EMPTY);
    else n_pass++;
    n_checks++;
    if ({CENA, CENB} !== 2'b11) $display("FAIL async_reset_cen: CENA/CENB=%b%b expected 11", CENA, CENB);
    else n_pass++;
    @(negedge CLK);
    RST_N = 1;
    drive_cycle(1, 0, 0, 18'h2468A);
    drive_cycle(0, 1, 0, '0);
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_simultaneous();
    test_stream();
    test_flush();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d words never popped, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ram_fifo_ctrl
